// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: memory-op codes and FSM states.
package lsu_pkg;

    localparam int REG_BUS      = 32;
    localparam int MEM_ADDR_BUS = 32;
    localparam int REG_ADDR_BUS = 5;
    localparam int MEM_OP_BUS   = 4;

    typedef enum logic [MEM_OP_BUS-1:0] {
        MEMOP_NONE = 4'd0,
        MEMOP_LB   = 4'd1,
        MEMOP_LH   = 4'd2,
        MEMOP_LW   = 4'd3,
        MEMOP_LBU  = 4'd4,
        MEMOP_LHU  = 4'd5,
        MEMOP_SB   = 4'd6,
        MEMOP_SH   = 4'd7,
        MEMOP_SW   = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/lsu_fmt.sv
// Combinational store/load lane formatting and alignment check for the LSU.
import lsu_pkg::*;

module lsu_fmt (
    input  logic [1:0]  i_off,
    input  logic [3:0]  i_op,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_rdata,
    output logic        o_misalign
);

    logic [31:0] w_rsh;
    logic [3:0]  w_mask;

    always_comb begin
        o_wdata    = i_wdata << {i_off, 3'b000};
        w_rsh      = i_rdata >> {i_off, 3'b000};
        w_mask     = 4'b0000;
        o_rdata    = w_rsh;
        o_misalign = 1'b0;
        case (i_op)
            MEMOP_SB:  w_mask = 4'b0001;
            MEMOP_SH: begin
                w_mask     = 4'b0011;
                o_misalign = i_off[0];
            end
            MEMOP_SW: begin
                w_mask     = 4'b1111;
                o_misalign = |i_off;
            end
            MEMOP_LB:  o_rdata = {{24{w_rsh[7]}}, w_rsh[7:0]};
            MEMOP_LBU: o_rdata = {24'h0, w_rsh[7:0]};
            MEMOP_LH: begin
                o_rdata    = {{16{w_rsh[15]}}, w_rsh[15:0]};
                o_misalign = i_off[0];
            end
            MEMOP_LHU: begin
                o_rdata    = {16'h0, w_rsh[15:0]};
                o_misalign = i_off[0];
            end
            MEMOP_LW:  o_misalign = |i_off;
            default: ;
        endcase
        // Strobe bits shifted past lane 3 are dropped, not wrapped.
        o_wstrb = w_mask << i_off;
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one memory op at a time over a valid/ready dmem port.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
import lsu_pkg::*;

module lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_i,
    input  logic [31:0] inst_addr_i,
    input  logic        reg_we_i,
    input  logic [4:0]  reg_waddr_i,
    input  logic [31:0] reg_wdata_i,
    input  logic        csr_we_i,
    input  logic [31:0] csr_waddr_i,
    input  logic [31:0] csr_wdata_i,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic        flush_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        reg_we_o,
    output logic [4:0]  reg_waddr_o,
    output logic [31:0] reg_wdata_o,
    output logic        csr_we_o,
    output logic [31:0] csr_waddr_o,
    output logic [31:0] csr_wdata_o,
    output logic        stall_req_o,
    output logic        dmem_req_valid_o,
    input  logic        dmem_req_ready_i,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_wstrb_o,
    input  logic        dmem_rsp_valid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        misalign_o
);

`ifdef LSU_MISALIGN_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    lsu_state_e  r_state, w_next;
    logic [31:0] r_ldata;
    logic        r_kill;

    logic        w_is_load, w_is_store, w_is_mem;
    logic [31:0] w_fmt_rdata;
    logic        w_fmt_misalign;
    logic        w_sel_ld, w_kill_we;

    assign w_is_load  = (mem_op_i == MEMOP_LB)  || (mem_op_i == MEMOP_LH) ||
                        (mem_op_i == MEMOP_LW)  || (mem_op_i == MEMOP_LBU) ||
                        (mem_op_i == MEMOP_LHU);
    assign w_is_store = (mem_op_i == MEMOP_SB)  || (mem_op_i == MEMOP_SH) ||
                        (mem_op_i == MEMOP_SW);
    assign w_is_mem   = w_is_load || w_is_store;

    lsu_fmt u_fmt (
        .i_off      (mem_addr_i[1:0]),
        .i_op       (mem_op_i),
        .i_wdata    (mem_wdata_i),
        .i_rdata    (dmem_rdata_i),
        .o_wdata    (dmem_wdata_o),
        .o_wstrb    (dmem_wstrb_o),
        .o_rdata    (w_fmt_rdata),
        .o_misalign (w_fmt_misalign)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ldata <= '0;
            r_kill  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_RESP && dmem_rsp_valid_i && w_is_load)
                r_ldata <= w_fmt_rdata;
            // A late flush cannot cancel the access, only its writeback.
            if (r_state == ST_DONE)
                r_kill <= 1'b0;
            else if ((r_state == ST_REQ || r_state == ST_RESP) && flush_i)
                r_kill <= 1'b1;
        end
    end

    always_comb begin
        w_next           = r_state;
        stall_req_o      = 1'b0;
        dmem_req_valid_o = 1'b0;
        misalign_o       = 1'b0;
        w_sel_ld         = 1'b0;
        w_kill_we        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_is_mem && !flush_i) begin
                    if (TRAP_EN && w_fmt_misalign) begin
                        misalign_o = 1'b1;
                    end else begin
                        stall_req_o = 1'b1;
                        w_next      = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                stall_req_o      = 1'b1;
                dmem_req_valid_o = 1'b1;
                if (dmem_req_ready_i)
                    w_next = ST_RESP;
            end
            ST_RESP: begin
                stall_req_o = 1'b1;
                if (dmem_rsp_valid_i)
                    w_next = ST_DONE;
            end
            ST_DONE: begin
                w_sel_ld  = w_is_load;
                w_kill_we = r_kill;
                w_next    = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign dmem_we_o   = w_is_store;
    assign dmem_addr_o = {mem_addr_i[31:2], 2'b00};

    assign inst_o      = inst_i;
    assign inst_addr_o = inst_addr_i;
    assign reg_we_o    = reg_we_i & ~(w_kill_we | misalign_o);
    assign reg_waddr_o = reg_waddr_i;
    assign reg_wdata_o = w_sel_ld ? r_ldata : reg_wdata_i;
    assign csr_we_o    = csr_we_i & ~w_kill_we;
    assign csr_waddr_o = csr_waddr_i;
    assign csr_wdata_o = csr_wdata_i;

endmodule

// File: doc/lsu.md
# lsu

Load/store unit of the NPC pipeline, sitting between the ex→lsu pipeline register and `lsu_wbu`. Accepts one memory operation at a time and runs it over a valid/ready data-memory port. Aligns store data and byte strobes, and aligns plus sign- or zero-extends load data. Holds the pipeline through `stall_req_o` until the access completes, then presents the writeback bundle for `lsu_wbu` to capture.

## Interface
Parameters: none. Widths come from the shared defines (`RegBus` = 32, `MemAddrBus` = 32, `RegAddrBus` = 5, `MemOpBus` = 4).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- inst_i / inst_addr_i  in  32/32  instruction and its PC; passed through to `inst_o` / `inst_addr_o`
- reg_we_i, reg_waddr_i, reg_wdata_i  in  1/5/32  GPR write request; `reg_wdata_i` is the ALU result for non-memory ops
- csr_we_i, csr_waddr_i, csr_wdata_i  in  1/32/32  CSR write request; passed through
- mem_op_i  in  4  memory-op code (NONE, LB, LH, LW, LBU, LHU, SB, SH, SW)
- mem_addr_i  in  32  effective address
- mem_wdata_i  in  32  store source (rs2)
- flush_i  in  1  pipeline flush
- inst_o, inst_addr_o, reg_we_o, reg_waddr_o, reg_wdata_o, csr_we_o, csr_waddr_o, csr_wdata_o  out  —  writeback bundle to `lsu_wbu`
- stall_req_o  out  1  stall request to the pipeline controller
- dmem_req_valid_o  out  1  memory request valid
- dmem_req_ready_i  in  1  memory request accepted
- dmem_we_o  out  1  1 = write
- dmem_addr_o  out  32  word-aligned address (`{mem_addr_i[31:2], 2'b00}`)
- dmem_wdata_o  out  32  lane-shifted store data
- dmem_wstrb_o  out  4  byte strobes
- dmem_rsp_valid_i  in  1  response valid (reads and writes)
- dmem_rdata_i  in  32  read data
- misalign_o  out  1  misaligned-access exception pulse (only with the config macro)

## Operation
FSM states: IDLE, REQ, RESP, DONE. Reset puts the FSM in IDLE and clears the load-data register and the kill flag.

- **IDLE**
  - `mem_op_i` == NONE: the bundle passes through combinationally; `stall_req_o` = 0.
  - Memory op present and `flush_i` = 0: `stall_req_o` = 1, next state REQ.
  - Memory op present and `flush_i` = 1: stay in IDLE; no request is issued.
- **REQ**
  - `dmem_req_valid_o` = 1; address, data, strobe and `we` are held stable.
  - On `dmem_req_ready_i` = 1, go to RESP.
  - A request is never withdrawn once `dmem_req_valid_o` is raised.
- **RESP**
  - Wait for `dmem_rsp_valid_i`.
  - On a load, capture the formatted `dmem_rdata_i` into the load-data register.
  - Then go to DONE.
- **DONE**
  - `stall_req_o` = 0.
  - `reg_wdata_o` = the load-data register for loads, `reg_wdata_i` for stores.
  - Next state is IDLE unconditionally, so the same op is never reissued.
- `stall_req_o` = 1 in IDLE(op present), REQ and RESP.
- **Kill flag**
  - Set by `flush_i` in REQ or RESP. The transaction still completes.
  - In DONE with the flag set, `reg_we_o` = 0 and `csr_we_o` = 0.
  - The flag clears on leaving DONE.
  - Stores already sent are not undone.
- **Store formatting**
  - `dmem_wdata_o` = `mem_wdata_i << (8*addr[1:0])`.
  - `dmem_wstrb_o` = `({SB:0001, SH:0011, SW:1111} << addr[1:0])`, truncated to 4 bits.
  - Loads drive `dmem_wstrb_o` = 0.
- **Load formatting**
  - Shift: `r = dmem_rdata_i >> (8*addr[1:0])`, zero-filled.
  - Then take byte or halfword and sign-extend (LB, LH) or zero-extend (LBU, LHU). LW uses `r` directly.
- **Reset mid-transaction:** the FSM returns to IDLE at once and `dmem_req_valid_o` drops. The memory side must be reset together with this block.

## Timing
- Zero-wait memory (ready in the REQ cycle, response the next cycle): op visible in cycle 0; REQ in cycle 1; RESP in cycle 2; DONE in cycle 3.
  - `stall_req_o` is high in cycles 0–2.
  - `lsu_wbu` captures the result at the end of cycle 3.
- Each memory wait cycle adds one cycle in REQ or RESP.
- A response arriving in the same cycle as ready is not legal. The protocol requires at least one cycle between them.
- Non-memory ops add zero latency.

## Configuration
- **`LSU_MISALIGN_TRAP_EN` defined**
  - An access is misaligned if it is LH/LHU/SH with `addr[0]` ≠ 0, or LW/SW with `addr[1:0]` ≠ 0.
  - In IDLE, a misaligned op issues no request and does not stall.
  - `misalign_o` = 1 for that cycle, with `reg_we_o` = 0.
- **Undefined**
  - No check is made; `misalign_o` is tied to 0.
  - The truncation and shift rules above apply. Example: SH at offset 3 gives `wstrb` = 1000.

## Structure
- `defines.v` gains: `MemOpBus`, the MemOp encodings (`MemOp_None` .. `MemOp_SW`), and the LSU state encodings.
- Sub-module `lsu_fmt` is purely combinational: address bits, op and data in; wdata, wstrb, formatted rdata and the misalign flag out.
- The FSM and the output muxing stay in `lsu`.

## Test plan
- **Load byte:** LB, addr 0x8000_0003, rdata 0x80FF_1234 → `reg_wdata_o` = 0xFFFF_FF80. Zero-wait: `stall_req_o` is high for 3 cycles.
- **Store halfword:** SH, addr 0x8000_0002, rs2 0x0000_ABCD → `dmem_addr_o` = 0x8000_0000, wdata = 0xABCD_0000, wstrb = 1100, `dmem_we_o` = 1.
- **Backpressure:** LHU with `dmem_req_ready_i` low for 4 cycles, then response after 2 more cycles, rdata 0x0000_F00D at offset 0 → `reg_wdata_o` = 0x0000_F00D. The request fields stay stable throughout REQ.
- **Flush during access:** `flush_i` pulses in RESP of an LW with `reg_we_i` = 1 → the transaction completes and DONE shows `reg_we_o` = 0. A flush in IDLE with SW pending → no `dmem_req_valid_o` is ever raised.
- **Misaligned, macro on:** LW at 0x8000_0001 → `misalign_o` = 1 for one cycle, no memory request, `stall_req_o` = 0. Macro off: request issued to 0x8000_0000.
- **Reset during REQ:** assert `rst` while in REQ → next cycle FSM is IDLE, `dmem_req_valid_o` = 0, all bundle outputs follow their inputs.
